mxu_host: RTL
=============

Name: mxu_host

Overview:
- Host-side initiator for the mxu matrix unit. It is the writer/reader at the other end of the mxu cache write port and result read port.
- Accepts a byte stream holding matrix A then matrix B, and writes each byte into the mxu cache. It then writes the start byte, waits for the unit's done pulse, and reads back the SIZE*SIZE results.
- Results leave on a valid/ready stream.
- Sits between the system-side buffer/DMA and one mxu instance.

Parameters:
- SIZE, 4: matrix dimension; must match the attached mxu.
- RD_LAT, 1: cycles from driving araddr to rdata being valid (0 allowed: same cycle).
- TIMEOUT, 1024: maximum WAIT cycles before the job is aborted.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_start  in  1  single-cycle job request; honoured only in IDLE.
- busy  out  1  high whenever state is not IDLE.
- timeout  out  1  sticky abort flag; cleared by the next accepted cmd_start.
- in_valid  in  1  operand byte valid.
- in_ready  out  1  operand byte accepted when in_valid & in_ready.
- in_data  in  8  operand byte. Bytes 0..S*S-1 are A row-major; bytes S*S..2*S*S-1 are B row-major.
- awaddr  out  32  mxu cache write address.
- wdata  out  9  mxu cache write data; bit 8 is always 0.
- wready  out  1  mxu write strobe.
- awready  out  1  mxu write strobe; always equal to wready.
- araddr  out  32  mxu result select; only the low log2(S*S) bits are meaningful, upper bits are 0.
- rdata  in  32  mxu result.
- mxu_done  in  1  done pulse from mxu control.
- out_valid  out  1  result valid.
- out_ready  in  1  result accepted when out_valid & out_ready.
- out_data  out  32  result word k.
- out_last  out  1  high with word k = S*S-1.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE; all counters 0.
  - All outputs 0: busy, timeout, in_ready, awaddr, wdata, wready, awready, araddr, out_valid, out_data, out_last.
- Write strobes:
  - Registered outputs. wready and awready are asserted together for exactly one cycle per write.
  - Both are 0 in every cycle that is not a write cycle.
  - awaddr and wdata return to 0 after each write.
- IDLE:
  - cmd_start=1 -> LOAD on the next edge; clears timeout and the byte index n.
  - mxu_done is ignored.
- LOAD:
  - in_ready=1 while n < 2*S*S.
  - Each accepted byte is registered. In the next cycle the block drives awaddr = n+1, wdata = {0, in_data}, wready = awready = 1, and n increments.
  - Back-to-back bytes give back-to-back write cycles; there is no back-pressure from mxu.
  - When the last byte is accepted, in_ready drops in the same cycle it is sampled (combinational on n).
  - The state moves to START once that last write has been driven.
- START:
  - One write cycle: awaddr = 0, wdata = 9'h001, strobes = 1.
  - Then -> WAIT with the wait counter cleared.
- WAIT:
  - No strobes.
  - mxu_done=1 -> READ with k = 0.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without done: timeout <= 1, -> IDLE.
  - If done and the timeout limit occur in the same cycle, done wins.
- READ, per word k:
  - Drive araddr = k.
  - After RD_LAT cycles, capture rdata into out_data and set out_valid = 1; out_last = (k == S*S-1).
  - araddr and out_data are held stable until out_ready.
  - On the handshake: out_valid drops for at least one cycle. If k was the last word -> IDLE; otherwise k+1 and repeat.
  - With RD_LAT = 0, capture happens in the cycle araddr is driven, and the next word is presented 1 cycle after the handshake.
- General rules:
  - cmd_start outside IDLE is ignored.
  - in_valid outside LOAD is ignored (in_ready = 0).
  - mxu_done outside WAIT is ignored.
  - Reset mid-operation aborts immediately. The mxu cache is not cleared; the next job overwrites all 2*S*S+1 bytes.
  - Index widths: n needs log2(2*S*S)+1 bits; k needs log2(S*S) bits, and the transition after the last word must be taken before k wraps.

Test Plan:
- SIZE=4, RD_LAT=1, A=identity, B bytes 1..16, in_valid held high:
  - Required: 32 consecutive write cycles to awaddr 1..32 with the stated data, then awaddr 0 / wdata 1.
  - With a model mxu asserting done 20 cycles later: 16 outputs equal B (1..16), out_last only on word 15.
- in_valid toggling 1/0 every cycle during LOAD -> writes appear only the cycle after each accepted byte, addresses still contiguous 1..32, no strobe in gap cycles.
- out_ready low for 5 cycles on word 3 -> out_valid, out_data and araddr=3 held stable, no word skipped or duplicated.
- mxu_done never asserted, TIMEOUT=64 -> timeout=1 and busy=0 exactly 64 cycles after the start write; the next cmd_start clears timeout.
- reset pulled low after 10 bytes in LOAD -> all outputs 0 asynchronously. A fresh job after release starts again at awaddr 1.
- cmd_start pulsed during WAIT and a stray mxu_done during LOAD -> both ignored; the sequence completes normally.

Source files
------------

// File: rtl/mxu_host.sv
// Host-side initiator for one mxu instance: streams A and B into the mxu cache,
// kicks the unit, waits for done (with timeout) and streams the results back out.
module mxu_host #(
  parameter int SIZE    = 4,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  output logic        busy,
  output logic        timeout,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [31:0] awaddr,
  output logic [8:0]  wdata,
  output logic        wready,
  output logic        awready,
  output logic [31:0] araddr,
  input  logic [31:0] rdata,
  input  logic        mxu_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last
);

  localparam int NWORDS = SIZE * SIZE;
  localparam int NBYTES = 2 * NWORDS;
  localparam int NW     = $clog2(NBYTES) + 1;
  localparam int KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int TW     = $clog2(TIMEOUT) + 1;
  localparam int LW     = $clog2(RD_LAT + 1) + 1;

  localparam logic [NW-1:0] N_LAST = NW'(NBYTES);
  localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] L_CAP  = LW'(RD_LAT);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [KW-1:0] k_q, k_d;
  logic [TW-1:0] wait_q, wait_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   awaddr_q, awaddr_d;
  logic [8:0]    wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic [31:0]   araddr_q, araddr_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          load_ready;

  // in_ready depends only on n so it falls the cycle after the last byte is taken
  assign load_ready = (state_q == ST_LOAD) && (n_q < N_LAST);

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    k_d         = k_q;
    wait_d      = wait_q;
    lat_d       = lat_q;
    timeout_d   = timeout_q;
    awaddr_d    = '0;
    wdata_d     = '0;
    wr_d        = 1'b0;
    araddr_d    = araddr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          state_d   = ST_LOAD;
          timeout_d = 1'b0;
          n_d       = '0;
        end
      end
      ST_LOAD: begin
        if (in_valid && load_ready) begin
          awaddr_d = 32'(n_q) + 32'd1;
          wdata_d  = {1'b0, in_data};
          wr_d     = 1'b1;
          n_d      = n_q + 1'b1;
        end else if (n_q == N_LAST) begin
          // last operand write is on the bus now; the start write follows directly
          state_d  = ST_START;
          awaddr_d = '0;
          wdata_d  = 9'h001;
          wr_d     = 1'b1;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
        wait_d  = '0;
      end
      ST_WAIT: begin
        if (mxu_done) begin
          state_d  = ST_READ;
          k_d      = '0;
          lat_d    = '0;
          araddr_d = '0;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_d == T_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_READ: begin
        if (!out_valid_q) begin
          if (lat_q == L_CAP) begin
            out_valid_d = 1'b1;
            out_data_d  = rdata;
            out_last_d  = (k_q == K_LAST);
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          lat_d       = '0;
          if (k_q == K_LAST) begin
            state_d  = ST_IDLE;
            araddr_d = '0;
          end else begin
            k_d      = k_q + 1'b1;
            araddr_d = 32'(k_d);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      k_q         <= '0;
      wait_q      <= '0;
      lat_q       <= '0;
      timeout_q   <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      araddr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      wait_q      <= wait_d;
      lat_q       <= lat_d;
      timeout_q   <= timeout_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      araddr_q    <= araddr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign timeout   = timeout_q;
  assign in_ready  = load_ready;
  assign awaddr    = awaddr_q;
  assign wdata     = wdata_q;
  assign wready    = wr_q;
  assign awready   = wr_q;
  assign araddr    = araddr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
